tc_irq_ctrl: RTL and testbench
==============================

Name: tc_irq_ctrl

Overview:
Interrupt scheduler for the timer/counter block's interrupt sources: TC0/TC1 compare-A, compare-B and overflow.
- Latches per-source event pulses into pending flags (TIFR view) and applies the TIMSK mask and the global interrupt enable.
- Arbitrates by fixed priority and drives a single request/vector handshake to the CPU core.
- Sits between the timer/counter instances and the core's interrupt unit, replacing ad-hoc request/executed wiring inside each timer.

Parameters:
NSRC, 6, number of interrupt sources. Index 0..5 = TC0 COMPA, TC0 COMPB, TC0 OVF, TC1 COMPA, TC1 COMPB, TC1 OVF. Lower index has higher priority.
VEC_W, 8, width of the vector output.
VEC_BASE, 14, vector number of source 0. Source k maps to VEC_BASE+k.

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous, active-low reset
flag_set  input  NSRC  one-cycle event pulses from the timers, one bit per source
mask  input  NSRC  TIMSK enable bits, level
status_reg_interrupt_enable  input  1  global I bit from the status register
sw_clr  input  1  software write strobe to the flag register
sw_clr_data  input  NSRC  write-1-to-clear data for pending flags and overrun bits
interrupt_request  output  1  request to the core, level
irq_vector  output  VEC_W  vector of the granted source, valid while interrupt_request=1
interrupt_ack  input  1  one-cycle pulse: core has accepted the vector
interrupt_executed  input  1  one-cycle pulse: ISR return (RETI) complete
flags  output  NSRC  pending flags (TIFR readback)
overrun  output  NSRC  sticky bits: event arrived while the same flag was already pending
busy  output  1  high in REQ or SERVICE

Behaviour:
Reset (rst=0 at an edge):
- flags, overrun, interrupt_request, irq_vector and busy all go to 0; FSM goes to IDLE.
- Reset overrides every other input in that cycle, including mid-REQ and mid-SERVICE.

Flags, per bit k, each edge:
- flag_set[k]=1 sets flags[k].
- flag_set[k]=1 with flags[k] already 1 (and not being cleared this cycle) also sets overrun[k].
- sw_clr=1 with sw_clr_data[k]=1 clears flags[k] and overrun[k].
- Auto-clear: interrupt_ack clears the flag of the granted source.
- Set and clear in the same cycle: set wins; flags[k] stays 1 and overrun[k] is not set.
- Flags latch regardless of mask and the I bit.

Eligibility and arbitration:
- eligible = flags & mask, gated by status_reg_interrupt_enable.
- Winner = lowest eligible index, evaluated from registered flags only.

FSM states: IDLE, REQ, SERVICE.
- IDLE: if any eligible bit is set, latch the winner index, assert interrupt_request, drive irq_vector = VEC_BASE+winner, go to REQ. Otherwise stay.
- REQ:
  - Hold the index and vector stable; a higher-priority flag arriving in REQ does not preempt.
  - interrupt_ack=1: auto-clear the winner's flag, drop interrupt_request, go to SERVICE.
  - Withdraw with no ack: if the winner's flag is cleared by software, its mask bit falls, or the I bit falls, drop interrupt_request and return to IDLE next edge. If ack and withdraw occur in the same cycle, ack wins.
- SERVICE: interrupt_request=0; no nesting. interrupt_executed=1 moves to IDLE. Re-arbitration starts in IDLE on the following edge.
- interrupt_ack in IDLE or SERVICE is ignored. interrupt_executed in IDLE or REQ is ignored.

Latency:
- flag_set sampled at edge N gives flags=1 after N and interrupt_request=1 after N+1.
- Back-to-back: interrupt_executed at edge M gives the next request after M+1.

irq_vector:
- Holds its last value in SERVICE and IDLE. Meaningful only while interrupt_request=1.
- Width: VEC_BASE+NSRC-1 must fit in VEC_W bits; vector arithmetic is unsigned with no wrap.

Test Plan:
- Reset and single source: hold rst=0 for 2 cycles, release, mask=6'b000001, I bit=1, pulse flag_set[0] -> flags=000001 after 1 cycle, interrupt_request=1 with irq_vector=14 after 2 cycles. Ack -> flags=0, busy=1. interrupt_executed -> IDLE, busy=0.
- Priority: flag_set=6'b101000 in the same cycle, mask=all ones -> vector 17 (source 3) granted first. After ack and executed, vector 19 (source 5) is granted.
- Masked and disabled: mask=0, pulse flag_set[2] -> flags[2]=1, no request. Raise mask[2] with the I bit low -> no request. Set the I bit -> request with vector 16.
- Withdraw: in REQ for source 1, sw_clr with sw_clr_data=000010 -> request drops within 1 cycle, FSM returns to IDLE, flags=0. An ack pulse afterwards has no effect.
- Overrun and collision: pulse flag_set[4] twice without service -> overrun[4]=1. Pulse flag_set[4] in the same cycle as its ack -> flags[4] stays 1 and is re-requested after interrupt_executed. sw_clr with sw_clr_data=010000 -> flags[4]=0, overrun[4]=0.
- Reset mid-service: drive rst=0 while in SERVICE -> all outputs 0 on the next edge. A subsequent interrupt_executed pulse is ignored.

Source files
------------

// File: rtl/tc_irq_ctrl.sv
// Timer/counter interrupt scheduler: latches TC0/TC1 event pulses into pending flags,
// applies mask and global enable, and runs a fixed-priority request/ack/RETI handshake.
module tc_irq_ctrl #(
  parameter int NSRC     = 6,
  parameter int VEC_W    = 8,
  parameter int VEC_BASE = 14
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NSRC-1:0]  flag_set,
  input  logic [NSRC-1:0]  mask,
  input  logic             status_reg_interrupt_enable,
  input  logic             sw_clr,
  input  logic [NSRC-1:0]  sw_clr_data,
  output logic             interrupt_request,
  output logic [VEC_W-1:0] irq_vector,
  input  logic             interrupt_ack,
  input  logic             interrupt_executed,
  output logic [NSRC-1:0]  flags,
  output logic [NSRC-1:0]  overrun,
  output logic             busy
);

  localparam int IDX_W = (NSRC > 1) ? $clog2(NSRC) : 1;

  typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_e;

  state_e           state_q;
  logic [NSRC-1:0]  flags_q, flags_d;
  logic [NSRC-1:0]  ovr_q, ovr_d;
  logic [NSRC-1:0]  sw_hit, clr, elig;
  logic [IDX_W-1:0] idx_q, win;
  logic             any_elig, ack_ok, withdraw;
  logic             req_q, busy_q;
  logic [VEC_W-1:0] vec_q;

  always_comb begin
    ack_ok = (state_q == REQ) && interrupt_ack;
    sw_hit = sw_clr ? sw_clr_data : '0;
    clr    = sw_hit;
    if (ack_ok) clr[idx_q] = 1'b1;
    // A new event beats any clear in the same cycle and then does not count as an overrun.
    flags_d = flag_set | (flags_q & ~clr);
    ovr_d   = ~sw_hit & (ovr_q | (flag_set & flags_q & ~clr));

    elig     = flags_q & mask & {NSRC{status_reg_interrupt_enable}};
    any_elig = |elig;
    win      = '0;
    for (int k = NSRC - 1; k >= 0; k--) begin
      if (elig[k]) win = IDX_W'(k);
    end

    // Pending request is withdrawn once its source would no longer be eligible.
    withdraw = ~(flags_d[idx_q] & mask[idx_q] & status_reg_interrupt_enable);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      flags_q <= '0;
      ovr_q   <= '0;
      idx_q   <= '0;
      req_q   <= 1'b0;
      busy_q  <= 1'b0;
      vec_q   <= '0;
    end else begin
      flags_q <= flags_d;
      ovr_q   <= ovr_d;
      case (state_q)
        IDLE: begin
          if (any_elig) begin
            state_q <= REQ;
            idx_q   <= win;
            req_q   <= 1'b1;
            busy_q  <= 1'b1;
            vec_q   <= VEC_W'(VEC_BASE) + VEC_W'(win);
          end
        end
        REQ: begin
          if (interrupt_ack) begin
            state_q <= SERVICE;
            req_q   <= 1'b0;
          end else if (withdraw) begin
            state_q <= IDLE;
            req_q   <= 1'b0;
            busy_q  <= 1'b0;
          end
        end
        SERVICE: begin
          if (interrupt_executed) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          req_q   <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign interrupt_request = req_q;
  assign irq_vector        = vec_q;
  assign flags             = flags_q;
  assign overrun           = ovr_q;
  assign busy              = busy_q;

endmodule

// File: tb/tb_tc_irq_ctrl.sv
// Bench for tc_irq_ctrl: directed scenarios plus random traffic, each cycle compared
// against a behavioural model of the pending/arbitration/handshake rules.
module tb_tc_irq_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] flag_set, mask, sw_clr_data;
  logic       ien, sw_clr, ack, exec;
  logic       interrupt_request, busy;
  logic [7:0] irq_vector;
  logic [5:0] flags, overrun;

  int vectors = 0;
  int miscompares = 0;

  logic [5:0] m_flags, m_ovr;
  logic       m_req, m_busy;
  logic [7:0] m_vec;
  int         m_mode, m_idx;   // mode: 0 idle, 1 requesting, 2 in service

  tc_irq_ctrl #(.NSRC(6), .VEC_W(8), .VEC_BASE(14)) dut (
    .clk(clk), .rst(rst), .flag_set(flag_set), .mask(mask),
    .status_reg_interrupt_enable(ien), .sw_clr(sw_clr), .sw_clr_data(sw_clr_data),
    .interrupt_request(interrupt_request), .irq_vector(irq_vector),
    .interrupt_ack(ack), .interrupt_executed(exec),
    .flags(flags), .overrun(overrun), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic model_step();
    logic [5:0] nf, novr;
    bit sc, cl;
    int w;
    if (!rst) begin
      m_flags = '0; m_ovr = '0; m_req = 0; m_busy = 0; m_vec = '0;
      m_mode = 0; m_idx = 0;
      return;
    end
    for (int k = 0; k < 6; k++) begin
      sc = sw_clr && sw_clr_data[k];
      cl = sc || (m_mode == 1 && ack && m_idx == k);
      nf[k]   = flag_set[k] || (m_flags[k] && !cl);
      novr[k] = !sc && (m_ovr[k] || (flag_set[k] && m_flags[k] && !cl));
    end
    case (m_mode)
      0: begin
        w = -1;
        for (int k = 5; k >= 0; k--) if (m_flags[k] && mask[k] && ien) w = k;
        if (w >= 0) begin
          m_mode = 1; m_idx = w; m_req = 1; m_vec = 8'(14 + w);
        end
      end
      1: begin
        if (ack) begin
          m_mode = 2; m_req = 0;
        end else if (!(nf[m_idx] && mask[m_idx] && ien)) begin
          m_mode = 0; m_req = 0;
        end
      end
      default: if (exec) m_mode = 0;
    endcase
    m_flags = nf;
    m_ovr   = novr;
    m_busy  = (m_mode != 0);
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet();
    rst = 1; flag_set = '0; sw_clr = 0; sw_clr_data = '0; ack = 0; exec = 0;
  endtask

  task automatic test_reset_single();
    for (int s = 0; s < 7; s++) begin
      quiet();
      mask = 6'b000001; ien = 1;
      case (s)
        0, 1: rst = 0;
        2: flag_set = 6'b000001;
        4: ack = 1;
        5: exec = 1;
        default: ;
      endcase
      cycle();
      vectors++;
      if ({interrupt_request, busy, irq_vector, flags, overrun} !== {m_req, m_busy, m_vec, m_flags, m_ovr}) begin
        miscompares++;
        $display("FAIL reset_single step %0d: got req=%b busy=%b vec=%0d flags=%b ovr=%b, want req=%b busy=%b vec=%0d flags=%b ovr=%b",
                 s, interrupt_request, busy, irq_vector, flags, overrun, m_req, m_busy, m_vec, m_flags, m_ovr);
      end
      vectors++;
      if ((s == 1 && {interrupt_request, busy, irq_vector, flags, overrun} !== 21'd0) ||
          (s == 2 && flags !== 6'b000001) ||
          (s == 3 && {interrupt_request, irq_vector} !== {1'b1, 8'd14}) ||
          (s == 4 && {flags, busy} !== {6'b0, 1'b1}) ||
          (s == 5 && busy !== 1'b0)) begin
        miscompares++;
        $display("FAIL reset_single_const step %0d: got req=%b vec=%0d flags=%b busy=%b", s, interrupt_request, irq_vector, flags, busy);
      end
    end
  endtask

  task automatic test_priority();
    for (int s = 0; s < 8; s++) begin
      quiet();
      mask = 6'b111111; ien = 1;
      case (s)
        0: rst = 0;
        1: flag_set = 6'b101000;
        3: ack = 1;
        4: exec = 1;
        6: ack = 1;
        7: exec = 1;
        default: ;
      endcase
      cycle();
      vectors++;
      if ({interrupt_request, busy, irq_vector, flags, overrun} !== {m_req, m_busy, m_vec, m_flags, m_ovr}) begin
        miscompares++;
        $display("FAIL priority step %0d: got req=%b busy=%b vec=%0d flags=%b ovr=%b, want req=%b busy=%b vec=%0d flags=%b ovr=%b",
                 s, interrupt_request, busy, irq_vector, flags, overrun, m_req, m_busy, m_vec, m_flags, m_ovr);
      end
      vectors++;
      if ((s == 2 && {interrupt_request, irq_vector} !== {1'b1, 8'd17}) ||
          (s == 5 && {interrupt_request, irq_vector} !== {1'b1, 8'd19})) begin
        miscompares++;
        $display("FAIL priority_const step %0d: got req=%b vec=%0d", s, interrupt_request, irq_vector);
      end
    end
  endtask

  task automatic test_masked();
    for (int s = 0; s < 8; s++) begin
      quiet();
      mask = (s < 3) ? 6'b000000 : 6'b000100;
      ien  = (s >= 5);
      case (s)
        0: rst = 0;
        1: flag_set = 6'b000100;
        6: ack = 1;
        7: exec = 1;
        default: ;
      endcase
      cycle();
      vectors++;
      if ({interrupt_request, busy, irq_vector, flags, overrun} !== {m_req, m_busy, m_vec, m_flags, m_ovr}) begin
        miscompares++;
        $display("FAIL masked step %0d: got req=%b busy=%b vec=%0d flags=%b ovr=%b, want req=%b busy=%b vec=%0d flags=%b ovr=%b",
                 s, interrupt_request, busy, irq_vector, flags, overrun, m_req, m_busy, m_vec, m_flags, m_ovr);
      end
      vectors++;
      if ((s == 4 && {interrupt_request, flags} !== {1'b0, 6'b000100}) ||
          (s == 5 && {interrupt_request, irq_vector} !== {1'b1, 8'd16})) begin
        miscompares++;
        $display("FAIL masked_const step %0d: got req=%b vec=%0d flags=%b", s, interrupt_request, irq_vector, flags);
      end
    end
  endtask

  task automatic test_withdraw();
    for (int s = 0; s < 6; s++) begin
      quiet();
      mask = 6'b111111; ien = 1;
      case (s)
        0: rst = 0;
        1: flag_set = 6'b000010;
        3: begin sw_clr = 1; sw_clr_data = 6'b000010; end
        4: ack = 1;
        default: ;
      endcase
      cycle();
      vectors++;
      if ({interrupt_request, busy, irq_vector, flags, overrun} !== {m_req, m_busy, m_vec, m_flags, m_ovr}) begin
        miscompares++;
        $display("FAIL withdraw step %0d: got req=%b busy=%b vec=%0d flags=%b ovr=%b, want req=%b busy=%b vec=%0d flags=%b ovr=%b",
                 s, interrupt_request, busy, irq_vector, flags, overrun, m_req, m_busy, m_vec, m_flags, m_ovr);
      end
      vectors++;
      if ((s == 2 && {interrupt_request, irq_vector} !== {1'b1, 8'd15}) ||
          (s >= 3 && {interrupt_request, busy, flags} !== 8'd0)) begin
        miscompares++;
        $display("FAIL withdraw_const step %0d: got req=%b busy=%b vec=%0d flags=%b", s, interrupt_request, busy, irq_vector, flags);
      end
    end
  endtask

  task automatic test_overrun_collision();
    for (int s = 0; s < 10; s++) begin
      quiet();
      mask = 6'b111111;
      ien  = (s >= 4);
      case (s)
        0: rst = 0;
        1, 3: flag_set = 6'b010000;
        5: begin ack = 1; flag_set = 6'b010000; end
        6: exec = 1;
        8: begin sw_clr = 1; sw_clr_data = 6'b010000; end
        default: ;
      endcase
      cycle();
      vectors++;
      if ({interrupt_request, busy, irq_vector, flags, overrun} !== {m_req, m_busy, m_vec, m_flags, m_ovr}) begin
        miscompares++;
        $display("FAIL overrun step %0d: got req=%b busy=%b vec=%0d flags=%b ovr=%b, want req=%b busy=%b vec=%0d flags=%b ovr=%b",
                 s, interrupt_request, busy, irq_vector, flags, overrun, m_req, m_busy, m_vec, m_flags, m_ovr);
      end
      vectors++;
      if ((s == 3 && overrun !== 6'b010000) ||
          (s == 5 && {flags, interrupt_request} !== {6'b010000, 1'b0}) ||
          (s == 7 && {interrupt_request, irq_vector} !== {1'b1, 8'd18}) ||
          (s == 8 && {flags, overrun} !== 12'd0)) begin
        miscompares++;
        $display("FAIL overrun_const step %0d: got req=%b vec=%0d flags=%b ovr=%b", s, interrupt_request, irq_vector, flags, overrun);
      end
    end
  endtask

  task automatic test_reset_mid_service();
    for (int s = 0; s < 7; s++) begin
      quiet();
      mask = 6'b111111; ien = 1;
      case (s)
        0, 4: rst = 0;
        1: flag_set = 6'b000001;
        3: ack = 1;
        5: exec = 1;
        default: ;
      endcase
      cycle();
      vectors++;
      if ({interrupt_request, busy, irq_vector, flags, overrun} !== {m_req, m_busy, m_vec, m_flags, m_ovr}) begin
        miscompares++;
        $display("FAIL reset_mid step %0d: got req=%b busy=%b vec=%0d flags=%b ovr=%b, want req=%b busy=%b vec=%0d flags=%b ovr=%b",
                 s, interrupt_request, busy, irq_vector, flags, overrun, m_req, m_busy, m_vec, m_flags, m_ovr);
      end
      vectors++;
      if ((s == 3 && busy !== 1'b1) ||
          (s >= 4 && {interrupt_request, busy, irq_vector, flags, overrun} !== 21'd0)) begin
        miscompares++;
        $display("FAIL reset_mid_const step %0d: got req=%b busy=%b vec=%0d flags=%b ovr=%b", s, interrupt_request, busy, irq_vector, flags, overrun);
      end
    end
  endtask

  task automatic test_random();
    for (int s = 0; s < 600; s++) begin
      quiet();
      rst = (s == 0 || $urandom_range(0, 99) == 0) ? 1'b0 : 1'b1;
      for (int k = 0; k < 6; k++) flag_set[k] = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 15) == 0) mask = 6'($urandom);
      ien = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 11) == 0) begin
        sw_clr = 1; sw_clr_data = 6'($urandom);
      end
      ack  = ($urandom_range(0, 2) == 0);
      exec = ($urandom_range(0, 3) == 0);
      cycle();
      vectors++;
      if ({interrupt_request, busy, irq_vector, flags, overrun} !== {m_req, m_busy, m_vec, m_flags, m_ovr}) begin
        miscompares++;
        $display("FAIL random cycle %0d: got req=%b busy=%b vec=%0d flags=%b ovr=%b, want req=%b busy=%b vec=%0d flags=%b ovr=%b",
                 s, interrupt_request, busy, irq_vector, flags, overrun, m_req, m_busy, m_vec, m_flags, m_ovr);
      end
    end
  endtask

  initial begin
    quiet();
    mask = '0; ien = 0;
    test_reset_single();
    test_priority();
    test_masked();
    test_withdraw();
    test_overrun_collision();
    test_reset_mid_service();
    mask = 6'b111111;
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
